// File: rtl/game_countdown_timer.sv
// ---------------------------------------------------------------------------
// game_countdown_timer
//   Round countdown timer for the game FSM. A prescaler divides clk down to
//   one game second; each second the two-digit BCD count is decremented from
//   GAME_SECS toward 00. Reaching 00 raises time_up (held until timer_reset)
//   and parks the timer in EXPIRED. The FSM holds the timer idle and reloaded
//   by driving timer_reset high.
//
//   Optional feature macro: TIMER_BONUS_EN
//     When defined, a bonus_add pulse in RUN adds BONUS_SECS to the count,
//     saturating at 99. When undefined, the port and adder do not exist.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   timer_reset  in   1  synchronous hold/reload (level), highest priority
//   pause        in   1  freezes prescaler and count while in RUN
//   bonus_add    in   1  one-cycle bonus pulse (TIMER_BONUS_EN only)
//   time_up      out  1  registered, 1 from expiry until timer_reset
//   sec_tick     out  1  registered one-cycle pulse per counted second
//   secs_tens    out  4  registered BCD tens digit of remaining seconds
//   secs_ones    out  4  registered BCD ones digit of remaining seconds
//   warn         out  1  combinational, RUN and count <= WARN_SECS
// ---------------------------------------------------------------------------
module game_countdown_timer #(
  parameter int CLKS_PER_SEC = 50_000_000,
  parameter int GAME_SECS    = 60,
  parameter int WARN_SECS    = 10,
  parameter int BONUS_SECS   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timer_reset,
  input  logic       pause,
`ifdef TIMER_BONUS_EN
  input  logic       bonus_add,
`endif
  output logic       time_up,
  output logic       sec_tick,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       warn
);

  localparam int             PW         = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0]  PS_LAST    = PW'(CLKS_PER_SEC - 1);
  localparam logic [3:0]     RELOAD_TEN = 4'(GAME_SECS / 10);
  localparam logic [3:0]     RELOAD_ONE = 4'(GAME_SECS % 10);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t        state, state_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic [3:0]    tens_next, ones_next;
  logic          time_up_next, sec_tick_next;
  logic          tick;
  logic [7:0]    count_bin;

  // Binary view of the BCD count, used for the warning compare and bonus math.
  assign count_bin = (8'(secs_tens) * 8'd10) + 8'(secs_ones);

  // A second elapses on this cycle's edge (timer_reset suppresses it).
  assign tick = (state == RUN) && !timer_reset && !pause && (prescaler == PS_LAST);

  assign warn = (state == RUN) && (count_bin <= 8'(WARN_SECS));

`ifdef TIMER_BONUS_EN
  // Bonus result: count, minus one if a second ends on the same edge, plus
  // the bonus, clamped to 99. Widened so large bonuses cannot wrap.
  logic       bonus_hit;
  logic [8:0] bonus_sum;
  logic [7:0] bonus_sat;

  assign bonus_hit = bonus_add && (state == RUN) && !timer_reset;
  assign bonus_sum = 9'(count_bin) - 9'(tick) + 9'(BONUS_SECS);
  assign bonus_sat = (bonus_sum > 9'd99) ? 8'd99 : bonus_sum[7:0];
`else
  // Without the bonus feature the count can only decrement.
`endif

  // State and datapath registers; reset acts immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      secs_tens <= RELOAD_TEN;
      secs_ones <= RELOAD_ONE;
      time_up   <= 1'b0;
      sec_tick  <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      secs_tens <= tens_next;
      secs_ones <= ones_next;
      time_up   <= time_up_next;
      sec_tick  <= sec_tick_next;
    end
  end

  // Next-state and datapath logic. timer_reset overrides everything; in RUN
  // the prescaler advances unless paused and a terminal count decrements the
  // BCD digits, expiring on the 01 -> 00 step.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    tens_next      = secs_tens;
    ones_next      = secs_ones;
    time_up_next   = time_up;
    sec_tick_next  = 1'b0;

    if (timer_reset) begin
      state_next     = IDLE;
      prescaler_next = '0;
      tens_next      = RELOAD_TEN;
      ones_next      = RELOAD_ONE;
      time_up_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = RUN;
        end
        RUN: begin
          if (!pause) begin
            if (tick) begin
              prescaler_next = '0;
              sec_tick_next  = 1'b1;
              if ((secs_tens == 4'd0) && (secs_ones == 4'd1)) begin
                ones_next    = 4'd0;
                time_up_next = 1'b1;
                state_next   = EXPIRED;
              end else if (secs_ones == 4'd0) begin
                ones_next = 4'd9;
                tens_next = secs_tens - 4'd1;
              end else begin
                ones_next = secs_ones - 4'd1;
              end
            end else begin
              prescaler_next = prescaler + 1'b1;
            end
          end
        end
        EXPIRED: begin
          time_up_next = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase

`ifdef TIMER_BONUS_EN
      // A bonus replaces the decrement result and cancels a coincident expiry.
      if (bonus_hit) begin
        tens_next    = 4'(bonus_sat / 8'd10);
        ones_next    = 4'(bonus_sat % 8'd10);
        state_next   = RUN;
        time_up_next = 1'b0;
      end
`else
      // No bonus path: the decrement above is the only count update.
`endif
    end
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_game_countdown_timer
//   Directed bench for game_countdown_timer with CLKS_PER_SEC=4,
//   GAME_SECS=12, WARN_SECS=10, BONUS_SECS=5. Expected sec_tick events are
//   queued by the stimulus with their cycle and digits; a monitor pops and
//   compares on every observed tick. Static conditions are checked directly.
//   Define TIMER_BONUS_EN to also exercise the bonus feature.
// ---------------------------------------------------------------------------
module tb_game_countdown_timer;

  localparam int CPS = 4;
  localparam int GS  = 12;
  localparam int WS  = 10;
  localparam int BS  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       timer_reset;
  logic       pause;
`ifdef TIMER_BONUS_EN
  logic       bonus_add;
`endif
  logic       time_up;
  logic       sec_tick;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       warn;

  typedef struct {
    int cyc;
    int tens;
    int ones;
    int time_up;
    int warn;
  } tick_exp_t;

  tick_exp_t exp_q[$];
  tick_exp_t mon_e;
  int cyc    = 0;
  int checks = 0;
  int passes = 0;
  int base;

  game_countdown_timer #(
    .CLKS_PER_SEC(CPS),
    .GAME_SECS   (GS),
    .WARN_SECS   (WS),
    .BONUS_SECS  (BS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .timer_reset(timer_reset),
    .pause      (pause),
`ifdef TIMER_BONUS_EN
    .bonus_add  (bonus_add),
`endif
    .time_up    (time_up),
    .sec_tick   (sec_tick),
    .secs_tens  (secs_tens),
    .secs_ones  (secs_ones),
    .warn       (warn)
  );

  always #5 clk = ~clk;

  // Cycle index: value after the N-th rising edge is N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic tr, input logic ps);
    timer_reset = tr;
    pause       = ps;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one expected tick: edge index and the count it leaves behind.
  task automatic pushTick(input int at, input int count);
    tick_exp_t e;
    e.cyc     = at;
    e.tens    = count / 10;
    e.ones    = count % 10;
    e.time_up = (count == 0) ? 1 : 0;
    e.warn    = ((count <= WS) && (count != 0)) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed tick must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sec_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_tick", cyc, -1);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("tick_cycle",   cyc,       mon_e.cyc);
        checkOutput("tick_tens",    secs_tens, mon_e.tens);
        checkOutput("tick_ones",    secs_ones, mon_e.ones);
        checkOutput("tick_time_up", time_up,   mon_e.time_up);
        checkOutput("tick_warn",    warn,      mon_e.warn);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
`ifdef TIMER_BONUS_EN
    bonus_add = 1'b0;
`endif
    waitCycles(2);
    applyStimulus(1'b0, 1'b0);
    waitCycles(3);

    // Asynchronous reset mid-cycle, checked before any further edge
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_tens",     secs_tens, 1);
    checkOutput("reset_ones",     secs_ones, 2);
    checkOutput("reset_time_up",  time_up,   0);
    checkOutput("reset_sec_tick", sec_tick,  0);
    checkOutput("reset_warn",     warn,      0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    waitCycles(3);
    checkOutput("hold_tens",    secs_tens, 1);
    checkOutput("hold_ones",    secs_ones, 2);
    checkOutput("hold_time_up", time_up,   0);
    checkOutput("hold_warn",    warn,      0);

    // Full round: tick i lands 1 + 4*i edges after releasing timer_reset
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    for (int i = 1; i <= GS; i++) pushTick(base + 1 + CPS * i, GS - i);
    waitCycles(1 + CPS * GS);
    checkOutput("expired_tens",    secs_tens, 0);
    checkOutput("expired_ones",    secs_ones, 0);
    checkOutput("expired_time_up", time_up,   1);
    checkOutput("expired_warn",    warn,      0);

    // EXPIRED holds for 20 cycles, pause has no effect
    applyStimulus(1'b0, 1'b1);
    waitCycles(10);
    applyStimulus(1'b0, 1'b0);
    waitCycles(10);
    checkOutput("expired_hold_time_up", time_up,   1);
    checkOutput("expired_hold_tens",    secs_tens, 0);
    checkOutput("expired_hold_ones",    secs_ones, 0);
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    checkOutput("reload_time_up", time_up,   0);
    checkOutput("reload_tens",    secs_tens, 1);
    checkOutput("reload_ones",    secs_ones, 2);

    // Pause at prescaler=2 for 7 cycles; tick 2 cycles after release
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    waitCycles(3);
    applyStimulus(1'b0, 1'b1);
    waitCycles(7);
    applyStimulus(1'b0, 1'b0);
    pushTick(base + 12, 11);
    pushTick(base + 16, 10);
    waitCycles(9);

    // timer_reset at prescaler=3: no tick, reload, prescaler restarts
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    checkOutput("abort_sec_tick", sec_tick,  0);
    checkOutput("abort_tens",     secs_tens, 1);
    checkOutput("abort_ones",     secs_ones, 2);
    checkOutput("abort_warn",     warn,      0);
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    pushTick(base + 5, 11);
    waitCycles(6);

`ifdef TIMER_BONUS_EN
    // Seventeen bonuses while paused: 12 + 85 = 97, then saturate at 99
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1);
    bonus_add = 1'b1;
    waitCycles(17);
    checkOutput("bonus_97_tens", secs_tens, 9);
    checkOutput("bonus_97_ones", secs_ones, 7);
    waitCycles(1);
    checkOutput("bonus_sat_tens", secs_tens, 9);
    checkOutput("bonus_sat_ones", secs_ones, 9);
    waitCycles(1);
    checkOutput("bonus_sat_hold", 10 * secs_tens + secs_ones, 99);
    bonus_add = 1'b0;

    // Bonus on the 01 -> 00 tick: count becomes 05, no expiry
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    for (int i = 1; i < GS; i++) pushTick(base + 1 + CPS * i, GS - i);
    pushTick(base + 1 + CPS * GS, BS);
    pushTick(base + 1 + CPS * (GS + 1), BS - 1);
    waitCycles(CPS * GS);
    bonus_add = 1'b1;
    waitCycles(1);
    bonus_add = 1'b0;
    checkOutput("bonus_tick_time_up", time_up,   0);
    checkOutput("bonus_tick_ones",    secs_ones, BS);
    waitCycles(5);
    checkOutput("bonus_after_time_up", time_up, 0);
`endif

    applyStimulus(1'b1, 1'b0);
    waitCycles(2);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
